// File: rtl/jam_host.sv
// jam_host: host-side cost table, engine reset sequencer and result checker for the JAM engine.
// Optional build macro JAM_HOST_TIMEOUT_EN adds a RUN-phase watchdog and the timeout output.
module jam_host #(
  parameter int TIMEOUT_CYCLES = 40500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ld_valid,
  input  logic [6:0] ld_data,
  output logic       ld_ready,
  input  logic [9:0] exp_min,
  input  logic [3:0] exp_count,
  output logic       jam_rst,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  input  logic [9:0] MinCost,
  input  logic [3:0] MatchCount,
  input  logic       Valid,
  output logic [9:0] got_min,
  output logic [3:0] got_count,
  output logic       done,
  output logic       pass,
  output logic       fail,
`ifdef JAM_HOST_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic [2:0] state_dbg
);

  // Load handshake: a word transfers on any posedge with ld_valid && ld_ready
  // while in LOAD; ld_valid is ignored in every other state.
  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] ptr;
  logic       hold_cnt;
  logic [6:0] tbl [64];

`ifdef JAM_HOST_TIMEOUT_EN
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);
  logic [16:0] run_cnt;
`endif

  assign state_dbg = state;
  assign Cost      = tbl[{W, J}];

  // Table contents survive reset; a word presented on a reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && state == S_LOAD && ld_valid) begin
      tbl[ptr] <= ld_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_LOAD;
      ptr       <= '0;
      hold_cnt  <= 1'b0;
      ld_ready  <= 1'b1;
      jam_rst   <= 1'b1;
      got_min   <= '0;
      got_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
`ifdef JAM_HOST_TIMEOUT_EN
      run_cnt   <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_valid) begin
            ptr <= ptr + 6'd1;
            if (ptr == 6'd63) begin
              state    <= S_HOLD;
              ld_ready <= 1'b0;
              hold_cnt <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          // Two full cycles of engine reset once the table is complete.
          if (hold_cnt) begin
            state   <= S_RUN;
            jam_rst <= 1'b0;
`ifdef JAM_HOST_TIMEOUT_EN
            run_cnt <= '0;
`endif
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (Valid) begin
            got_min   <= MinCost;
            got_count <= MatchCount;
            state     <= S_CHECK;
          end
`ifdef JAM_HOST_TIMEOUT_EN
          else if (run_cnt + 17'd1 == TO_LIMIT) begin
            timeout <= 1'b1;
            fail    <= 1'b1;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= S_DONE;
          end else begin
            run_cnt <= run_cnt + 17'd1;
          end
`endif
        end
        S_CHECK: begin
          // MatchCount is compared on its native 4 bits, wrapped value included.
          pass  <= (got_min == exp_min) && (got_count == exp_count);
          fail  <= !((got_min == exp_min) && (got_count == exp_count));
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_host.sv
// Self-checking bench for jam_host: table load, Cost readback, result capture/compare, reset and timeout.
module tb_jam_host;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ld_valid = 1'b0;
  logic [6:0] ld_data = '0;
  logic       ld_ready;
  logic [9:0] exp_min = '0;
  logic [3:0] exp_count = '0;
  logic       jam_rst;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic [6:0] Cost;
  logic [9:0] MinCost = '0;
  logic [3:0] MatchCount = '0;
  logic       Valid = 1'b0;
  logic [9:0] got_min;
  logic [3:0] got_count;
  logic       done;
  logic       pass;
  logic       fail;
  logic [2:0] state_dbg;
`ifdef JAM_HOST_TIMEOUT_EN
  logic       timeout;
`endif

  int errors = 0;
  int checks = 0;

  logic [6:0]  tbl_m [64];
  logic [6:0]  exp_q [$];
  logic [13:0] res_q [$];

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  jam_host #(
`ifdef JAM_HOST_TIMEOUT_EN
    .TIMEOUT_CYCLES(100)
`else
    .TIMEOUT_CYCLES(40500)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .exp_min(exp_min), .exp_count(exp_count),
    .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid),
    .got_min(got_min), .got_count(got_count),
    .done(done), .pass(pass), .fail(fail),
`ifdef JAM_HOST_TIMEOUT_EN
    .timeout(timeout),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ld_valid = 1'b0; Valid = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic fill_identity(input logic [6:0] diag, input logic [6:0] off);
    for (int i = 0; i < 64; i++) tbl_m[i] = (i[5:3] == i[2:0]) ? diag : off;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) tbl_m[i] = 7'($urandom_range(0, 127));
  endtask

  // Loads tbl_m; gaps inserts an idle cycle after every word; extras are dropped words.
  task automatic load_table(input bit gaps, input int extras);
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      ld_valid = 1'b1; ld_data = tbl_m[i];
      @(posedge CLK);
      if (gaps && i != 63) begin
        @(negedge CLK);
        ld_valid = 1'b0; ld_data = 7'h55;
        @(posedge CLK);
      end
    end
    #1;
    checks++;
    if (ld_ready !== 1'b0 || jam_rst !== 1'b1) begin
      errors++;
      $display("FAIL load_end: ld_ready=%b jam_rst=%b required 0/1", ld_ready, jam_rst);
    end
    for (int k = 0; k < extras + 2; k++) begin
      @(negedge CLK);
      ld_valid = (k < extras); ld_data = 7'h55;
      @(posedge CLK); #1;
      if (k < 2) begin
        checks++;
        if (jam_rst !== (k == 0)) begin
          errors++;
          $display("FAIL hold_jam_rst[%0d]: got %b required %b", k, jam_rst, (k == 0));
        end
      end
    end
    @(negedge CLK);
    ld_valid = 1'b0;
  endtask

  task automatic check_costs(input int n);
    for (int r = 0; r < n; r++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      @(negedge CLK);
      W = a[5:3]; J = a[2:0];
      exp_q.push_back(tbl_m[a]);
      #1;
      checks++;
      if (Cost !== exp_q.pop_front()) begin
        errors++;
        $display("FAIL cost[%0d][%0d]: got %0d required %0d", W, J, Cost, tbl_m[a]);
      end
    end
  endtask

  // Engine stub reports a result; host compares it against exp_min/exp_count.
  task automatic engine_result(input logic [9:0] mc, input logic [3:0] cnt,
                               input logic [9:0] emin, input logic [3:0] ecnt);
    logic [13:0] r;
    logic exp_pass;
    exp_pass = (mc == emin) && (cnt == ecnt);
    @(negedge CLK);
    exp_min = emin; exp_count = ecnt;
    MinCost = mc; MatchCount = cnt; Valid = 1'b1;
    res_q.push_back({mc, cnt});
    @(posedge CLK); #1;
    r = res_q.pop_front();
    checks++;
    if ({got_min, got_count} !== r || state_dbg !== ST_CHECK || done !== 1'b0) begin
      errors++;
      $display("FAIL capture: got %0d/%0d st=%0d done=%b required %0d/%0d st=3 done=0",
               got_min, got_count, state_dbg, done, r[13:4], r[3:0]);
    end
    @(negedge CLK);
    Valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b1 || pass !== exp_pass || fail !== !exp_pass || state_dbg !== ST_DONE) begin
      errors++;
      $display("FAIL verdict: done=%b pass=%b fail=%b st=%0d required 1/%b/%b/4",
               done, pass, fail, state_dbg, exp_pass, !exp_pass);
    end
    // Further engine activity must not disturb the frozen verdict.
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      MinCost = 10'h3ff; MatchCount = 4'hf; Valid = 1'b1; ld_valid = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if ({got_min, got_count} !== r || pass !== exp_pass || done !== 1'b1 || jam_rst !== 1'b0) begin
        errors++;
        $display("FAIL frozen[%0d]: got %0d/%0d pass=%b done=%b jam_rst=%b", k,
                 got_min, got_count, pass, done, jam_rst);
      end
    end
    @(negedge CLK);
    Valid = 1'b0; ld_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ld_ready !== 1'b1 || jam_rst !== 1'b1 || done !== 1'b0 || pass !== 1'b0 ||
        fail !== 1'b0 || got_min !== 10'd0 || got_count !== 4'd0 || state_dbg !== ST_LOAD) begin
      errors++;
      $display("FAIL reset: rdy=%b jr=%b done=%b pass=%b fail=%b min=%0d cnt=%0d st=%0d",
               ld_ready, jam_rst, done, pass, fail, got_min, got_count, state_dbg);
    end
  endtask

  task automatic test_identity();
    do_reset();
    fill_identity(7'd1, 7'd50);
    load_table(1'b0, 0);
    checks++;
    if (state_dbg !== ST_RUN) begin
      errors++;
      $display("FAIL run_entry: st=%0d required 2", state_dbg);
    end
    check_costs(12);
    engine_result(10'd8, 4'd1, 10'd8, 4'd1);
  endtask

  task automatic test_wrap_count();
    do_reset();
    for (int i = 0; i < 64; i++) tbl_m[i] = 7'd10;
    load_table(1'b0, 0);
    check_costs(4);
    engine_result(10'd80, 4'(40320 % 16), 10'd80, 4'd0);
  endtask

  task automatic test_mismatch();
    do_reset();
    fill_identity(7'd1, 7'd50);
    load_table(1'b0, 0);
    engine_result(10'd8, 4'd1, 10'd9, 4'd1);
  endtask

  task automatic test_gappy_load();
    do_reset();
    fill_identity(7'd1, 7'd50);
    load_table(1'b1, 5);
    @(negedge CLK);
    W = 3'd0; J = 3'd0;
    #1;
    checks++;
    if (Cost !== 7'd1) begin
      errors++;
      $display("FAIL extra_words: cost[0][0]=%0d required 1", Cost);
    end
    check_costs(8);
    engine_result(10'd8, 4'd1, 10'd8, 4'd1);
  endtask

  task automatic test_mid_reset();
    logic [9:0] dsum;
    bit seen_done;
    do_reset();
    fill_identity(7'd1, 7'd50);
    load_table(1'b0, 0);
    seen_done = 1'b0;
    repeat (100) begin
      @(posedge CLK); #1;
      if (done !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL run_idle: done=1 required 0 while Valid low");
    end
    @(negedge CLK);
    RST = 1'b1; ld_valid = 1'b1; ld_data = 7'h7f;
    @(posedge CLK); #1;
    checks++;
    if (jam_rst !== 1'b1 || ld_ready !== 1'b1 || done !== 1'b0 || state_dbg !== ST_LOAD) begin
      errors++;
      $display("FAIL mid_reset: jr=%b rdy=%b done=%b st=%0d required 1/1/0/0",
               jam_rst, ld_ready, done, state_dbg);
    end
    @(negedge CLK);
    RST = 1'b0; ld_valid = 1'b0;
    fill_random();
    load_table(1'b0, 0);
    check_costs(12);
    dsum = '0;
    for (int i = 0; i < 8; i++) dsum = dsum + 10'(tbl_m[i * 9]);
    engine_result(dsum, 4'd3, dsum, 4'd3);
  endtask

`ifdef JAM_HOST_TIMEOUT_EN
  task automatic test_timeout();
    bit early;
    do_reset();
    fill_identity(7'd1, 7'd50);
    load_table(1'b0, 0);
    early = 1'b0;
    for (int c = 1; c <= 99; c++) begin
      @(posedge CLK); #1;
      if (done !== 1'b0 || timeout !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early: fired before 100 RUN cycles");
    end
    @(posedge CLK); #1;
    checks++;
    if (timeout !== 1'b1 || fail !== 1'b1 || done !== 1'b1 || pass !== 1'b0 ||
        got_min !== 10'd0 || got_count !== 4'd0) begin
      errors++;
      $display("FAIL timeout: to=%b fail=%b done=%b pass=%b min=%0d required 1/1/1/0/0",
               timeout, fail, done, pass, got_min);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_identity();
    test_wrap_count();
    test_mismatch();
    test_gappy_load();
    test_mid_reset();
`ifdef JAM_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jam_host.md
# jam_host

Host-side responder and checker for the JAM cost-assignment engine. It holds the 8x8 worker/job cost table and answers the engine's W/J address requests with Cost in the same cycle. It holds the engine in reset until the table is loaded, then captures MinCost/MatchCount when Valid rises and compares them against expected values. It sits at the far end of the JAM W/J/Cost/Valid interface, in the test harness or the SoC wrapper.

## Interface

**Parameters**
- TIMEOUT_CYCLES, default 40500: maximum RUN cycles to wait for Valid; 17-bit compare. Used only with JAM_HOST_TIMEOUT_EN.

**Ports**
- CLK  in  1  sole clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- ld_valid  in  1  table load word present.
- ld_data  in  7  cost word, row-major (W then J).
- ld_ready  out  1  table accepting words.
- exp_min  in  10  expected MinCost, sampled in CHECK.
- exp_count  in  4  expected MatchCount, sampled in CHECK.
- jam_rst  out  1  registered reset driven to the engine's RST.
- W  in  3  engine worker address.
- J  in  3  engine job address.
- Cost  out  7  table[W][J], combinational.
- MinCost  in  10  engine result.
- MatchCount  in  4  engine result.
- Valid  in  1  engine result valid.
- got_min  out  10  captured MinCost.
- got_count  out  4  captured MatchCount.
- done  out  1  sticky; check finished.
- pass  out  1  sticky; results matched.
- fail  out  1  sticky; mismatch or timeout.
- timeout  out  1  sticky; present only with JAM_HOST_TIMEOUT_EN.

## Operation

- Storage: 64 x 7-bit registers, indexed by a 6-bit pointer {w,j}.
- Cost = table[{W,J}] combinationally in every state. Reads have no side effects.
- **LOAD** (reset state)
  - ld_ready=1, jam_rst=1.
  - Each cycle with ld_valid=1 writes ld_data at the pointer and increments the pointer.
  - On the write at pointer 63: go to HOLD and set ld_ready=0 the next cycle.
  - Cycles with ld_valid=0 do nothing; gaps are legal.
- **HOLD**
  - jam_rst=1 for exactly 2 cycles, then go to RUN.
  - Guarantees the engine sees at least one reset edge after the table is complete, and that its negedge-driven Valid is 0.
- **RUN**
  - jam_rst=0.
  - Valid is sampled only in this state.
  - First posedge with Valid=1: capture MinCost into got_min and MatchCount into got_count, then go to CHECK.
- **CHECK** (1 cycle)
  - pass = (got_min==exp_min && got_count==exp_count); fail = !pass.
  - done=1; go to DONE.
- **DONE**
  - Terminal; all outputs held; jam_rst stays 0.
  - Leaves only on RST.
- ld_valid is ignored outside LOAD, and ld_ready=0 there; extra words are dropped.
- MatchCount is the engine's 4-bit wrapped count. The comparison is exact on 4 bits, with no widening.

## Timing

- Reset values: state=LOAD, pointer=0, ld_ready=1, jam_rst=1, got_min=0, got_count=0, done=0, pass=0, fail=0, timeout=0. Table contents are not cleared.
- Cost has zero latency: valid in the same cycle that W/J change, before the engine samples it at the next posedge.
- Load: 64 accepted words, then 2 HOLD cycles, then RUN.
- Valid seen at posedge N gives captures at N. pass/fail/done are visible after posedge N+1.
- RST mid-operation, in any state: everything returns to reset values on that edge. jam_rst=1 from the next cycle, and the table must be reloaded in full.
- ld_valid asserted on the same edge as RST deasserting: the word is not written. The first write occurs on the first post-reset edge with ld_valid=1.

## Configuration

- Macro: JAM_HOST_TIMEOUT_EN.
- **Defined**
  - A 17-bit counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES before Valid: timeout=1, fail=1, done=1, pass=0, go to DONE. got_* are left at 0.
  - If Valid and the limit occur in the same cycle, Valid wins (normal capture).
- **Undefined**
  - No counter and no timeout port; RUN waits indefinitely.

## Test plan

- Load cost[w][j] = (w==j)?1:50 with exp_min=8, exp_count=1, real engine -> got_min=8, got_count=1, pass=1, fail=0, done=1.
- Load all entries = 10 with exp_min=80, exp_count=0 -> 40320 matches wrap to 0, so got_count=0 and pass=1.
- Identity table with exp_min=9 -> got_min=8, fail=1, pass=0, done stays 1 with outputs frozen.
- Load with ld_valid toggling every other cycle plus 5 extra words after the 64th -> same result as a contiguous load; extra words are not written (read table[0][0] unchanged).
- RST asserted 100 cycles into RUN -> the next cycle shows jam_rst=1, ld_ready=1, done=0. A reload with a new table gives the new correct result.
- JAM_HOST_TIMEOUT_EN with TIMEOUT_CYCLES=100 and a stub holding Valid=0 -> timeout=fail=done=1 after exactly 100 RUN cycles.
